// File: rtl/resp_misr_pkg.sv
// Shared types and MISR next-state function for the response compactor.
package resp_misr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned MaxWidth = 64;

    // One MISR step on the low `width` bits; upper bits of the result are zero.
    function automatic logic [MaxWidth-1:0] misr_next(
        input logic [MaxWidth-1:0] sig,
        input logic [MaxWidth-1:0] data,
        input logic [MaxWidth-1:0] poly,
        input int unsigned         width
    );
        logic [MaxWidth-1:0] mask;
        logic [MaxWidth-1:0] shifted;
        logic                msb;
        mask    = (MaxWidth'(1) << width) - MaxWidth'(1);
        msb     = |(sig & (MaxWidth'(1) << (width - 1)));
        shifted = (sig << 1) & mask;
        if (msb) begin
            shifted = shifted ^ (poly & mask);
        end
        return (shifted ^ data) & mask;
    endfunction

endpackage

// File: rtl/resp_misr_step.sv
// Combinational MISR step: next signature from current signature and one response word.
module misr_step
    import resp_misr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1D
) (
    input  logic [WIDTH-1:0] signature,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next_signature
);

    assign next_signature = WIDTH'(misr_next(MaxWidth'(signature), MaxWidth'(data),
                                             MaxWidth'(POLY), WIDTH));

endmodule

// File: rtl/resp_misr.sv
// Response compactor: folds a stream of response words into a MISR signature and
// compares the final signature against a golden value.
module resp_misr
    import resp_misr_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] POLY    = 8'h1D,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int unsigned      COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               resp_valid,
    input  logic [WIDTH-1:0]   resp_data,
    input  logic               resp_last,
    output logic               resp_ready,
    input  logic [WIDTH-1:0]   golden,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [WIDTH-1:0]   signature,
    output logic [COUNT_W-1:0] beat_count
);

    state_e               state_q;
    logic [WIDTH-1:0]     sig_q;
    logic [WIDTH-1:0]     sig_next;
    logic [COUNT_W-1:0]   beat_q;
    logic                 pass_q;

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_step (
        .signature      (sig_q),
        .data           (resp_data),
        .next_signature (sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sig_q   <= SEED;
            beat_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        sig_q   <= SEED;
                        beat_q  <= '0;
                        pass_q  <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // ready is implied by being in RUN, so valid alone qualifies a beat
                    if (resp_valid) begin
                        sig_q <= sig_next;
                        if (beat_q != '1) begin
                            beat_q <= beat_q + COUNT_W'(1);
                        end
                        if (resp_last) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    pass_q  <= (sig_q == golden);
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resp_ready = (state_q == StRun);
    assign busy       = (state_q == StRun) || (state_q == StCheck);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign beat_count = beat_q;

endmodule

// File: doc/resp_misr.md
RESP_MISR -- requirements
Module: resp_misr

Interface
REQ-001 Parameter WIDTH, default 8, response word width in bits; the block SHALL support WIDTH >= 2.
REQ-002 Parameter POLY, default 8'h1D, MISR feedback polynomial; bit i set means a tap into bit i.
REQ-003 Parameter SEED, default 0, signature value loaded at start of a run.
REQ-004 Parameter COUNT_W, default 16, beat counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  one-cycle pulse that begins a compaction run.
REQ-008 resp_valid  input  1  response word available.
REQ-009 resp_data  input  WIDTH  DUT response word.
REQ-010 resp_last  input  1  marks the final word of the run; qualified by resp_valid.
REQ-011 resp_ready  output  1  block accepts a response word this cycle.
REQ-012 golden  input  WIDTH  expected final signature, sampled in CHECK.
REQ-013 busy  output  1  high in RUN and CHECK.
REQ-014 done  output  1  high in DONE.
REQ-015 pass  output  1  compare result, valid while done is high.
REQ-016 signature  output  WIDTH  current MISR register.
REQ-017 beat_count  output  COUNT_W  number of accepted words this run.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, CHECK, DONE.
REQ-019 IDLE or DONE, start=1: signature<=SEED, beat_count<=0, pass<=0, next state RUN.
REQ-020 start SHALL be ignored in RUN and CHECK.
REQ-021 resp_ready SHALL be 1 exactly in RUN and 0 in all other states.
REQ-022 A beat transfers when resp_valid and resp_ready are both 1 on a rising edge.
REQ-023 Per beat: signature <= ({signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0)) ^ resp_data.
REQ-024 Per beat: beat_count increments by 1 and saturates at 2^COUNT_W-1.
REQ-025 A beat with resp_last=1 SHALL be compacted, then the FSM SHALL enter CHECK; resp_ready is 0 on the following cycle.
REQ-026 CHECK lasts one cycle: pass <= (signature == golden); next state DONE.
REQ-027 DONE holds signature, beat_count and pass stable until start or rst.
REQ-028 No beat in RUN (resp_valid=0) leaves signature and beat_count unchanged.
REQ-029 resp_last without resp_valid SHALL have no effect.

Reset
REQ-030 rst=1 on a rising edge: state IDLE, signature=SEED, beat_count=0, pass=0, done=0, busy=0, resp_ready=0.
REQ-031 rst SHALL take priority over start and over any beat in the same cycle, including mid-run.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the MISR next-state function.
REQ-033 The MISR next-state logic SHALL be a sub-module misr_step (signature, data, POLY -> next signature); the FSM and counter stay in resp_misr.

Verification (WIDTH=8, POLY=8'h1D, SEED=0)
REQ-034 start, then beats 8'h01, 8'h80, 8'h00 with last on the third, golden=8'h19 -> signature 8'h01, 8'h82, 8'h19; beat_count=3; done=1 two cycles after the last beat; pass=1.
REQ-035 Same stream, golden=8'h18 -> done=1, pass=0, signature=8'h19.
REQ-036 resp_valid toggled 1,0,0,1 in RUN with data 8'h01, 8'h80 -> result identical to the back-to-back case; resp_ready=0 in IDLE, CHECK and DONE.
REQ-037 rst asserted after the second beat of REQ-034 -> next cycle IDLE, signature=0, beat_count=0, resp_ready=0; a following start runs normally.
REQ-038 COUNT_W=2, five beats of 8'h00 with last on the fifth -> beat_count=3 (saturated), signature=0.
REQ-039 start pulsed during RUN -> ignored; start in DONE -> new run with signature=SEED and pass=0.
